// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU shift path.
// Holds the data-word width, counter width and shift-FSM state encoding.
package cpu_pkg;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/serial_right_shifter_shift_step.sv
// One right-shift step of 0..STEP positions.
// Vacated top bits are filled with fill_i.
module shift_step #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SW    = 5
) (
    input  logic [WIDTH-1:0] sreg_i,
    input  logic [SW-1:0]    s_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] sreg_o
);

    // Prepending a word of fill bits lets a plain logical shift supply the fill.
    assign sreg_o = WIDTH'({{WIDTH{fill_i}}, sreg_i} >> s_i);

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter with a start/busy/done handshake.
// Shifts up to STEP bit positions per cycle; amount is clamped to WIDTH.
module serial_right_shifter #(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH,
    parameter int unsigned AMT_W = 24,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    import cpu_pkg::*;

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntStep = CntW'(STEP);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             fill_q, fill_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_start, step_s, cnt_next;
    logic [WIDTH-1:0] sreg_shifted;

    // Compare at full width before truncating so large amounts cannot alias small ones.
    assign cnt_start = (amount >= AMT_W'(WIDTH)) ? CntMax : CntW'(amount);
    assign step_s    = (cnt_q > CntStep) ? CntStep : cnt_q;
    assign cnt_next  = cnt_q - step_s;

    shift_step #(
        .WIDTH (WIDTH),
        .SW    (CntW)
    ) u_shift_step (
        .sreg_i (sreg_q),
        .s_i    (step_s),
        .fill_i (fill_q),
        .sreg_o (sreg_shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
            result_q <= '0;
            fill_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            result_q <= result_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (cnt_start == '0) ? StDone : StShift;
            StShift: if (cnt_next == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sreg_d   = sreg_q;
        result_d = result_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d = data_in;
                    fill_d = arith & data_in[WIDTH-1];
                    cnt_d  = cnt_start;
                    if (cnt_start == '0) result_d = data_in;
                end
            end
            StShift: begin
                sreg_d = sreg_shifted;
                cnt_d  = cnt_next;
                if (cnt_next == '0) result_d = sreg_shifted;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        result = result_q;
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// Self-checking bench for serial_right_shifter (STEP=1 and STEP=4 instances).
// Expected results and latencies come from an arithmetic reference model.
module tb_serial_right_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic        arith = 1'b0;
    logic [23:0] data_in = '0;
    logic [23:0] amount = '0;
    logic        busy1, done1, busy4, done4;
    logic [23:0] result1, result4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_right_shifter #(.WIDTH(24), .AMT_W(24), .STEP(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .arith   (arith),
        .data_in (data_in),
        .amount  (amount),
        .busy    (busy1),
        .done    (done1),
        .result  (result1)
    );

    serial_right_shifter #(.WIDTH(24), .AMT_W(24), .STEP(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .arith   (arith),
        .data_in (data_in),
        .amount  (amount),
        .busy    (busy4),
        .done    (done4),
        .result  (result4)
    );

    function automatic logic [23:0] model_result(logic [23:0] d, logic a, logic [23:0] amt);
        logic signed [23:0] sd;
        if (amt >= 24) return (a && d[23]) ? 24'hFFFFFF : 24'h000000;
        sd = d;
        if (a) return sd >>> amt;
        return d >> amt;
    endfunction

    function automatic int model_latency(logic [23:0] amt, int step);
        int n;
        n = (amt >= 24) ? 24 : int'(amt);
        return (n + step - 1) / step;
    endfunction

    // Drives one request, scrambles inputs after acceptance, waits for done, returns to IDLE.
    task automatic launch(input logic [23:0] d, input logic a, input logic [23:0] amt,
                          input bit use4, output int lat, output logic [23:0] res);
        @(negedge clk);
        data_in = d;
        arith   = a;
        amount  = amt;
        if (use4) start4 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1  = 1'b0;
        start4  = 1'b0;
        data_in = 24'($urandom);
        arith   = 1'($urandom_range(0, 1));
        amount  = 24'($urandom);
        lat = 0;
        while (!(use4 ? done4 : done1) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) lat = -1;
        res = use4 ? result4 : result1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", busy1);
        end
        checks++;
        if (done1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", done1);
        end
        checks++;
        if (result1 !== 24'h0) begin
            failures++;
            $display("FAIL reset_result: got %h want 000000", result1);
        end
        checks++;
        if ({busy4, done4, result4} !== 26'h0) begin
            failures++;
            $display("FAIL reset_dut4: got %b/%b/%h want 0/0/000000", busy4, done4, result4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_logical_sweep();
        int lat;
        logic [23:0] res, exp;
        for (int n = 0; n <= 25; n++) begin
            exp = (n < 24) ? (24'h800000 >> n) : 24'h000000;
            launch(24'h800000, 1'b0, 24'(n), 1'b0, lat, res);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL sweep_result n=%0d: got %h want %h", n, res, exp);
            end
            checks++;
            if (lat != ((n < 24) ? n : 24)) begin
                failures++;
                $display("FAIL sweep_latency n=%0d: got %0d want %0d", n, lat, (n < 24) ? n : 24);
            end
        end
    endtask

    task automatic test_arith();
        int lat;
        logic [23:0] res, d, amt, exp;
        logic a;
        launch(24'h800000, 1'b1, 24'd4, 1'b0, lat, res);
        checks++;
        if (res !== 24'hF80000 || lat != 4) begin
            failures++;
            $display("FAIL arith_neg4: got %h lat %0d want F80000 lat 4", res, lat);
        end
        launch(24'h400000, 1'b1, 24'd4, 1'b0, lat, res);
        checks++;
        if (res !== 24'h040000 || lat != 4) begin
            failures++;
            $display("FAIL arith_pos4: got %h lat %0d want 040000 lat 4", res, lat);
        end
        launch(24'h800001, 1'b1, 24'hFFFFFF, 1'b0, lat, res);
        checks++;
        if (res !== 24'hFFFFFF || lat != 24) begin
            failures++;
            $display("FAIL arith_clamp: got %h lat %0d want FFFFFF lat 24", res, lat);
        end
        for (int i = 0; i < 30; i++) begin
            d   = 24'($urandom);
            a   = 1'($urandom_range(0, 1));
            amt = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 26));
            exp = model_result(d, a, amt);
            launch(d, a, amt, 1'b0, lat, res);
            checks++;
            if (res !== exp || lat != model_latency(amt, 1)) begin
                failures++;
                $display("FAIL random_op d=%h a=%b amt=%h: got %h lat %0d want %h lat %0d",
                         d, a, amt, res, lat, exp, model_latency(amt, 1));
            end
        end
    endtask

    task automatic test_busy_protect();
        int pulses, lat, cyc;
        logic [23:0] got;
        pulses = 0;
        lat = -1;
        got = '0;
        @(negedge clk);
        data_in = 24'h00FF00;
        amount  = 24'd8;
        arith   = 1'b0;
        start1  = 1'b1;
        @(posedge clk);
        #1;
        data_in = 24'h123456;
        amount  = 24'd3;
        arith   = 1'b1;
        for (cyc = 0; cyc < 30; cyc++) begin
            if (done1) begin
                pulses++;
                if (pulses == 1) begin
                    got = result1;
                    lat = cyc;
                end
                start1 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL busy_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (got !== 24'h0000FF || lat != 8) begin
            failures++;
            $display("FAIL busy_result: got %h lat %0d want 0000FF lat 8", got, lat);
        end
        checks++;
        if (busy1 !== 1'b0 || result1 !== 24'h0000FF) begin
            failures++;
            $display("FAIL busy_after: got busy %b result %h want 0 0000FF", busy1, result1);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] hold, d, amt, exp;
        logic a;
        int cyc;
        hold = 24'h0000FF;
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle op=%0d: got busy %b want 0", op, busy1);
            end
            d   = 24'($urandom);
            a   = 1'($urandom_range(0, 1));
            amt = (op == 3) ? 24'd0 : 24'($urandom_range(1, 26));
            exp = model_result(d, a, amt);
            data_in = d;
            arith   = a;
            amount  = amt;
            start1  = 1'b1;
            @(posedge clk);
            #1;
            cyc = 0;
            while (!done1 && cyc < 100) begin
                data_in = 24'($urandom);
                amount  = 24'($urandom);
                arith   = 1'($urandom_range(0, 1));
                checks++;
                if (result1 !== hold) begin
                    failures++;
                    $display("FAIL b2b_hold op=%0d: got %h want %h", op, result1, hold);
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if (result1 !== exp || cyc != model_latency(amt, 1)) begin
                failures++;
                $display("FAIL b2b_result op=%0d: got %h lat %0d want %h lat %0d",
                         op, result1, cyc, exp, model_latency(amt, 1));
            end
            hold = exp;
            @(posedge clk);
            #1;
            if (op == 7) start1 = 1'b0;
        end
    endtask

    task automatic test_step4();
        int lat;
        logic [23:0] res, d, amt, exp;
        logic a;
        launch(24'hFFFFFF, 1'b0, 24'd10, 1'b1, lat, res);
        checks++;
        if (res !== 24'h003FFF || lat != 3) begin
            failures++;
            $display("FAIL step4_directed: got %h lat %0d want 003FFF lat 3", res, lat);
        end
        for (int i = 0; i < 12; i++) begin
            d   = 24'($urandom);
            a   = 1'($urandom_range(0, 1));
            amt = ($urandom_range(0, 4) == 0) ? 24'($urandom) : 24'($urandom_range(0, 25));
            exp = model_result(d, a, amt);
            launch(d, a, amt, 1'b1, lat, res);
            checks++;
            if (res !== exp || lat != model_latency(amt, 4)) begin
                failures++;
                $display("FAIL step4_random d=%h a=%b amt=%h: got %h lat %0d want %h lat %0d",
                         d, a, amt, res, lat, exp, model_latency(amt, 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [23:0] res;
        launch(24'h800000, 1'b0, 24'd1, 1'b0, lat, res);
        checks++;
        if (res !== 24'h400000) begin
            failures++;
            $display("FAIL premid_result: got %h want 400000", res);
        end
        @(negedge clk);
        data_in = 24'h800000;
        amount  = 24'd20;
        arith   = 1'b1;
        start1  = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_before: got %b want 1", busy1);
        end
        // Assert reset between edges to prove it acts without a clock.
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 24'h0) begin
            failures++;
            $display("FAIL mid_reset_async: got %b/%b/%h want 0/0/000000", busy1, done1, result1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 24'h0) begin
            failures++;
            $display("FAIL mid_reset_idle: got %b/%b/%h want 0/0/000000", busy1, done1, result1);
        end
        launch(24'h800000, 1'b1, 24'd4, 1'b0, lat, res);
        checks++;
        if (res !== 24'hF80000 || lat != 4) begin
            failures++;
            $display("FAIL mid_reset_resume: got %h lat %0d want F80000 lat 4", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_logical_sweep();
        test_arith();
        test_busy_protect();
        test_back_to_back();
        test_step4();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
